// File: rtl/mem_arb_pkg.sv
// Shared types for the IF/MEM single-port memory arbiter.
// Holds the FSM state encoding and the access-owner encoding.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    DONE   = 2'd3
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arb_timer.sv
// Loadable up-counter with clear, enable and terminal-count flag; optional saturation at TC.
// Counts one per enabled cycle; clear beats load, load beats increment.
module mem_arb_timer #(
  parameter int           W   = 8,
  parameter logic [W-1:0] TC  = '1,
  parameter bit           SAT = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         tc
);

  assign tc = (cnt == TC);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (ld) begin
      cnt <= ld_val;
    end else if (en && !(SAT && tc)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises IF fetches and MEM loads/stores onto one memory port; data has priority, fetch starvation bounded.
// Grant to done is 2+ cycles; requesters stall until their done pulse, unacked accesses abort after TIMEOUT cycles.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_D_BURST = 4,
  parameter int TIMEOUT     = 255
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  input  logic              i_d_req,
  input  logic              i_d_we,
  input  logic [ADDR_W-1:0] i_d_addr,
  input  logic [DATA_W-1:0] i_d_wdata,
  output logic              o_if_done,
  output logic [DATA_W-1:0] o_if_rdata,
  output logic              o_d_done,
  output logic [DATA_W-1:0] o_d_rdata,
  output logic              o_err,
  output logic              o_stall,
  output logic              o_m_req,
  output logic              o_m_we,
  output logic [ADDR_W-1:0] o_m_addr,
  output logic [DATA_W-1:0] o_m_wdata,
  input  logic              i_m_ack,
  input  logic [DATA_W-1:0] i_m_rdata
);

  localparam int BURST_W = $clog2(MAX_D_BURST + 1);
  localparam int TMO_W   = 16;

  state_t state, state_nxt;
  owner_t owner;

  logic d_grant, i_grant, acked, timed_out;
  logic burst_full, tmo_last;
  logic [BURST_W-1:0] burst_cnt;
  logic [TMO_W-1:0]   tmo_cnt;
  logic               cnt_unused;

  assign cnt_unused = ^{burst_cnt, tmo_cnt};

  // Consecutive data grants taken while a fetch was waiting.
  mem_arb_timer #(
    .W   (BURST_W),
    .TC  (BURST_W'(MAX_D_BURST)),
    .SAT (1'b1)
  ) u_burst (
    .clk    (i_clk),
    .rst_n  (i_rst_n),
    .clr    (i_grant | (d_grant & ~i_if_req)),
    .ld     (1'b0),
    .ld_val ('0),
    .en     (d_grant & i_if_req),
    .cnt    (burst_cnt),
    .tc     (burst_full)
  );

  // Terminal count is TIMEOUT-1 so the abort lands after exactly TIMEOUT busy cycles.
  mem_arb_timer #(
    .W   (TMO_W),
    .TC  (TMO_W'(TIMEOUT - 1)),
    .SAT (1'b1)
  ) u_tmo (
    .clk    (i_clk),
    .rst_n  (i_rst_n),
    .clr    (d_grant | i_grant),
    .ld     (1'b0),
    .ld_val ('0),
    .en     (((state == BUSY_I) || (state == BUSY_D)) && !i_m_ack),
    .cnt    (tmo_cnt),
    .tc     (tmo_last)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    d_grant   = 1'b0;
    i_grant   = 1'b0;
    acked     = 1'b0;
    timed_out = 1'b0;
    case (state)
      IDLE: begin
        if (i_d_req && !(i_if_req && burst_full)) begin
          d_grant   = 1'b1;
          state_nxt = BUSY_D;
        end else if (i_if_req) begin
          i_grant   = 1'b1;
          state_nxt = BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        if (i_m_ack) begin
          acked     = 1'b1;
          state_nxt = DONE;
        end else if (tmo_last) begin
          timed_out = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign o_stall = (i_if_req | i_d_req) & (state != DONE);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      owner      <= OWN_I;
      o_m_req    <= 1'b0;
      o_m_we     <= 1'b0;
      o_m_addr   <= '0;
      o_m_wdata  <= '0;
      o_if_done  <= 1'b0;
      o_if_rdata <= '0;
      o_d_done   <= 1'b0;
      o_d_rdata  <= '0;
      o_err      <= 1'b0;
    end else begin
      o_if_done <= 1'b0;
      o_d_done  <= 1'b0;
      o_err     <= 1'b0;
      if (d_grant || i_grant) begin
        owner     <= d_grant ? OWN_D : OWN_I;
        o_m_req   <= 1'b1;
        o_m_we    <= d_grant & i_d_we;
        o_m_addr  <= d_grant ? i_d_addr : i_if_addr;
        o_m_wdata <= d_grant ? i_d_wdata : '0;
      end
      if (acked || timed_out) begin
        o_m_req <= 1'b0;
        o_err   <= timed_out;
        if (owner == OWN_I) begin
          o_if_done  <= 1'b1;
          o_if_rdata <= acked ? i_m_rdata : '0;
        end else begin
          o_d_done  <= 1'b1;
          o_d_rdata <= (acked && !o_m_we) ? i_m_rdata : '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with MAX_D_BURST=4 and TIMEOUT=8.
module tb_mem_port_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clk;
  logic              rst_n;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              if_done;
  logic [DATA_W-1:0] if_rdata;
  logic              d_done;
  logic [DATA_W-1:0] d_rdata;
  logic              err;
  logic              stall;
  logic              m_req;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic              m_ack;
  logic [DATA_W-1:0] m_rdata;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  mem_port_arbiter #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .MAX_D_BURST (4),
    .TIMEOUT     (8)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_if_req   (if_req),
    .i_if_addr  (if_addr),
    .i_d_req    (d_req),
    .i_d_we     (d_we),
    .i_d_addr   (d_addr),
    .i_d_wdata  (d_wdata),
    .o_if_done  (if_done),
    .o_if_rdata (if_rdata),
    .o_d_done   (d_done),
    .o_d_rdata  (d_rdata),
    .o_err      (err),
    .o_stall    (stall),
    .o_m_req    (m_req),
    .o_m_we     (m_we),
    .o_m_addr   (m_addr),
    .o_m_wdata  (m_wdata),
    .i_m_ack    (m_ack),
    .i_m_rdata  (m_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [31:0] exp_addr [6];
    int          req_cycles;

    exp_addr = '{32'h200, 32'h200, 32'h200, 32'h200, 32'h20, 32'h200};

    rst_n = 1'b0; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; m_ack = 1'b0; m_rdata = '0;
    tick(); tick();
    chk("rst_m_req", m_req, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_if_done", if_done, 0);
    chk("rst_d_done", d_done, 0);
    chk("rst_err", err, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_stall", stall, 0);
    rst_n = 1'b1;
    tick();

    // Fetch only, ack three cycles after o_m_req rises
    if_req = 1'b1; if_addr = 32'h40;
    #1;
    chk("f_stall_idle", stall, 1);
    tick();
    chk("f_m_req", m_req, 1);
    chk("f_m_addr", m_addr, 32'h40);
    chk("f_m_we", m_we, 0);
    tick(); tick(); tick();
    chk("f_m_req_held", m_req, 1);
    chk("f_no_early_done", if_done, 0);
    m_ack = 1'b1; m_rdata = 32'h8C220004;
    tick();
    m_ack = 1'b0;
    chk("f_done", if_done, 1);
    chk("f_rdata", if_rdata, 32'h8C220004);
    chk("f_err", err, 0);
    chk("f_m_req_drop", m_req, 0);
    chk("f_stall_done", stall, 0);
    if_req = 1'b0;
    tick();
    chk("f_done_pulse", if_done, 0);
    chk("f_rdata_held", if_rdata, 32'h8C220004);

    // Simultaneous fetch and store: store first
    if_req = 1'b1; if_addr = 32'h10;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD;
    tick();
    chk("s_m_addr", m_addr, 32'h100);
    chk("s_m_we", m_we, 1);
    chk("s_m_wdata", m_wdata, 32'hDEAD);
    chk("s_stall_busy", stall, 1);
    m_ack = 1'b1; m_rdata = 32'h12345678;
    tick();
    m_ack = 1'b0;
    chk("s_d_done", d_done, 1);
    chk("s_d_rdata_store", d_rdata, 0);
    chk("s_if_not_done", if_done, 0);
    chk("s_stall_done", stall, 0);
    d_req = 1'b0; d_we = 1'b0;
    tick();
    chk("s_idle_m_req", m_req, 0);
    chk("s_stall_idle", stall, 1);
    tick();
    chk("s_fetch_m_req", m_req, 1);
    chk("s_fetch_addr", m_addr, 32'h10);
    chk("s_fetch_we", m_we, 0);
    chk("s_stall_busy_i", stall, 1);
    m_ack = 1'b1; m_rdata = 32'hCAFE0001;
    tick();
    m_ack = 1'b0;
    chk("s_if_done", if_done, 1);
    chk("s_if_rdata", if_rdata, 32'hCAFE0001);
    chk("s_stall_done2", stall, 0);
    if_req = 1'b0;
    tick();

    // Starvation: both requests held, expect D D D D I D
    if_req = 1'b1; if_addr = 32'h20;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
    for (int n = 0; n < 6; n++) begin
      for (int k = 0; k < 10 && m_req !== 1'b1; k++) tick();
      chk($sformatf("b_grant%0d", n), m_req, 1);
      chk($sformatf("b_addr%0d", n), m_addr, exp_addr[n]);
      m_ack = 1'b1; m_rdata = 32'h1000 + n;
      tick();
      m_ack = 1'b0;
      if (exp_addr[n] == 32'h20) begin
        chk($sformatf("b_if_done%0d", n), if_done, 1);
        chk($sformatf("b_if_rdata%0d", n), if_rdata, 32'h1000 + n);
      end else begin
        chk($sformatf("b_d_done%0d", n), d_done, 1);
        chk($sformatf("b_d_rdata%0d", n), d_rdata, 32'h1000 + n);
      end
      if (n == 5) begin
        if_req = 1'b0; d_req = 1'b0;
      end
      tick();
    end

    // Timeout: no ack, 8 request cycles then done+err
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
    tick();
    req_cycles = 0;
    for (int k = 0; k < 20 && m_req === 1'b1; k++) begin
      req_cycles++;
      tick();
    end
    chk("t_req_cycles", req_cycles, 8);
    chk("t_d_done", d_done, 1);
    chk("t_err", err, 1);
    chk("t_d_rdata", d_rdata, 0);
    d_req = 1'b0;
    tick();
    chk("t_done_pulse", d_done, 0);
    chk("t_err_pulse", err, 0);
    chk("t_idle_m_req", m_req, 0);

    // Reset in the cycle after grant
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h400; d_wdata = 32'h55;
    tick();
    chk("r_m_req_before", m_req, 1);
    rst_n = 1'b0; d_req = 1'b0; d_we = 1'b0;
    tick();
    chk("r_m_req", m_req, 0);
    chk("r_m_we", m_we, 0);
    chk("r_m_addr", m_addr, 0);
    chk("r_m_wdata", m_wdata, 0);
    chk("r_if_rdata", if_rdata, 0);
    chk("r_d_done", d_done, 0);
    rst_n = 1'b1;
    m_ack = 1'b1;
    tick();
    m_ack = 1'b0;
    chk("r_no_done_d", d_done, 0);
    chk("r_no_done_i", if_done, 0);
    if_req = 1'b1; if_addr = 32'h44;
    tick();
    chk("r_fetch_addr", m_addr, 32'h44);
    chk("r_fetch_req", m_req, 1);
    m_ack = 1'b1; m_rdata = 32'h0BADF00D;
    tick();
    m_ack = 1'b0;
    chk("r_fetch_done", if_done, 1);
    chk("r_fetch_rdata", if_rdata, 32'h0BADF00D);
    chk("r_fetch_err", err, 0);
    if_req = 1'b0;
    tick();

    // Spurious ack in IDLE
    m_ack = 1'b1; m_rdata = 32'hFFFFFFFF;
    tick();
    m_ack = 1'b0;
    chk("a_if_done", if_done, 0);
    chk("a_d_done", d_done, 0);
    chk("a_m_req", m_req, 0);
    chk("a_if_rdata", if_rdata, 32'h0BADF00D);
    tick();
    chk("a_if_done2", if_done, 0);
    chk("a_m_req2", m_req, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end

endmodule
